// File: rtl/lms_ctr_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the lms_ctr input PIO: word address, strobes,
// 32-bit write data and registered read data (fixed read latency 1).
interface lms_ctr_pio_in_edge_if;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output read,
      output write,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  read,
      input  write,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/lms_ctr_pio_in_edge.sv
// Avalon-MM input PIO with level readback, per-bit edge capture (RW1C) and maskable irq.
// Define PIO_IN_SYNC_EN to insert a SYNC_STAGES-deep synchroniser in front of in_port.
module lms_ctr_pio_in_edge #(
   parameter int unsigned DATA_WIDTH  = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_MODE   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   lms_ctr_pio_in_edge_if.slave      avs,
   input  logic [DATA_WIDTH-1:0]     in_port,
   output logic                      irq
);

`ifdef PIO_IN_SYNC_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   localparam int unsigned CNT_W   = 3;
   localparam int unsigned ARM_CNT = SYNC_EN ? (SYNC_STAGES + 1) : 1;
   localparam logic [CNT_W-1:0] ARM_VAL = CNT_W'(ARM_CNT);

   logic [DATA_WIDTH-1:0] w_s;
   logic [DATA_WIDTH-1:0] r_prev;
   logic [DATA_WIDTH-1:0] w_edge;
   logic [DATA_WIDTH-1:0] w_edge_en;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_w1c;
   logic [DATA_WIDTH-1:0] r_mask;
   logic [DATA_WIDTH-1:0] r_cap;
   logic [CNT_W-1:0]      r_arm_cnt;
   logic                  w_armed;
   logic                  w_wr_mask;
   logic                  w_wr_cap;
   logic [31:0]           w_rd_mux;
   logic [31:0]           r_readdata;
   logic                  r_irq;
   logic                  w_unused_ok;

`ifdef PIO_IN_SYNC_EN
   logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];

   // Synchroniser chain; the last stage is the sampled value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= in_port;
         for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];
`else
   assign w_s = in_port;
`endif

   // Edge vector selected at elaboration; the reserved mode falls back to rising
   always_comb begin
      w_edge = w_s & ~r_prev;
      case (EDGE_MODE)
         1:       w_edge = ~w_s & r_prev;
         2:       w_edge = w_s ^ r_prev;
         default: w_edge = w_s & ~r_prev;
      endcase
   end

   assign w_armed   = (r_arm_cnt == ARM_VAL);
   assign w_edge_en = w_armed ? w_edge : '0;
   assign w_wdata   = avs.writedata[DATA_WIDTH-1:0];
   assign w_wr_mask = avs.write && (avs.address == 2'd2);
   assign w_wr_cap  = avs.write && (avs.address == 2'd3);
   assign w_w1c     = w_wr_cap ? w_wdata : '0;

   // Arm counter holds off capture while reset-valued flops settle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_arm_cnt <= '0;
      end else if (!w_armed) begin
         r_arm_cnt <= r_arm_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev <= '0;
      end else begin
         r_prev <= w_s;
      end
   end

   // New edges are OR-ed after the clear so a coincident edge keeps the bit set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cap <= '0;
      end else begin
         r_cap <= (r_cap & ~w_w1c) | w_edge_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mask <= '0;
      end else if (w_wr_mask) begin
         r_mask <= w_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_cap & r_mask);
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (avs.address)
         2'd0:    w_rd_mux = 32'(w_s);
         2'd2:    w_rd_mux = 32'(r_mask);
         2'd3:    w_rd_mux = 32'(r_cap);
         default: w_rd_mux = '0;
      endcase
   end

   // Read data refreshes every cycle; the read strobe is not needed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rd_mux;
      end
   end

   assign avs.readdata = r_readdata;
   assign irq          = r_irq;
   assign w_unused_ok  = &{1'b0, avs.read, avs.writedata};

endmodule
